// File: rtl/mio_bus_ctrl_pkg.sv
// Shared definitions for the memory/IO bus controller.
// Contents: bus width and constant words, access-size encodings, and the
// controller state encoding.
package mio_bus_ctrl_pkg;

    localparam int          RegBus     = 32;
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;
    localparam logic        ChipEnable = 1'b1;

    // Access size encodings on req_size_i; 2'b11 is reserved and faults.
    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;

    typedef enum logic [1:0] {
        MiocIdle   = 2'b00,
        MiocAccess = 2'b01,
        MiocResp   = 2'b10
    } mioc_state_e;

endpackage

// File: rtl/mio_bus_ctrl_lane.sv
// mio_lane: combinational big-endian byte-lane logic shared by the memory
// and IO paths.
// Ports:
//   size      in  2   access size (SizeByte/SizeHalf/SizeWord, 11 = fault)
//   addr_lo   in  2   low byte-address bits
//   sgn       in  1   sign-extend read data
//   wdata     in  32  right-justified store data
//   rdata     in  32  raw bus read data
//   sel       out 4   byte lanes, bit 3 = byte address 0
//   wdata_rep out 32  store data replicated across lanes
//   rdata_ext out 32  extracted and extended load data
//   misalign  out 1   misaligned access or reserved size
module mio_lane
    import mio_bus_ctrl_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        addr_lo,
    input  logic              sgn,
    input  logic [RegBus-1:0] wdata,
    input  logic [RegBus-1:0] rdata,
    output logic [3:0]        sel,
    output logic [RegBus-1:0] wdata_rep,
    output logic [RegBus-1:0] rdata_ext,
    output logic              misalign
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and halfword out of the big-endian word.
    always_comb begin
        byte_s = 8'h00;
        case (addr_lo)
            2'b00:   byte_s = rdata[31:24];
            2'b01:   byte_s = rdata[23:16];
            2'b10:   byte_s = rdata[15:8];
            2'b11:   byte_s = rdata[7:0];
            default: byte_s = 8'h00;
        endcase
        half_s = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    end

    // Per-size lane select, write replication, read extension and fault check.
    always_comb begin
        sel       = 4'b0000;
        wdata_rep = ZeroWord;
        rdata_ext = ZeroWord;
        misalign  = 1'b0;
        case (size)
            SizeByte: begin
                sel       = 4'b1000 >> addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{sgn & byte_s[7]}}, byte_s};
            end
            SizeHalf: begin
                misalign  = addr_lo[0];
                sel       = addr_lo[1] ? 4'b0011 : 4'b1100;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{sgn & half_s[15]}}, half_s};
            end
            SizeWord: begin
                misalign  = (addr_lo != 2'b00);
                sel       = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rdata;
            end
            default: begin
                misalign  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mio_bus_ctrl.sv
// mio_bus_ctrl: MEM-stage bus controller. Decodes each load/store to data
// memory or one of N_IO peripheral windows, steers big-endian byte lanes,
// waits for the selected target's ack with a timeout, and stalls the
// pipeline until the access completes or faults.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   req_*_i                   MEM-stage request (valid, we, size, signed, addr, wdata)
//   stallreq_o                hold the pipeline
//   done_o, err_o, rdata_o    completion pulse, fault flag, extended load data
//   mem_*                     data memory bus (ce, we, sel, addr, wdata, rdata, ack)
//   io_*                      peripheral bus; io_ce_o one-hot, io_addr_o is the
//                             in-window offset, io_rdata_i/io_ack_i per channel
module mio_bus_ctrl
    import mio_bus_ctrl_pkg::*;
#(
    parameter int          N_IO        = 4,
    parameter logic [31:0] IO_BASE     = 32'h1000_0000,
    parameter int          IO_WIN_LOG2 = 8,
    parameter int          TIMEOUT     = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid_i,
    input  logic                   req_we_i,
    input  logic [1:0]             req_size_i,
    input  logic                   req_signed_i,
    input  logic [31:0]            req_addr_i,
    input  logic [31:0]            req_wdata_i,
    output logic                   stallreq_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [31:0]            rdata_o,
    output logic                   mem_ce_o,
    output logic                   mem_we_o,
    output logic [3:0]             mem_sel_o,
    output logic [31:0]            mem_addr_o,
    output logic [31:0]            mem_wdata_o,
    input  logic [31:0]            mem_rdata_i,
    input  logic                   mem_ack_i,
    output logic [N_IO-1:0]        io_ce_o,
    output logic                   io_we_o,
    output logic [3:0]             io_sel_o,
    output logic [31:0]            io_addr_o,
    output logic [31:0]            io_wdata_o,
    input  logic [32*N_IO-1:0]     io_rdata_i,
    input  logic [N_IO-1:0]        io_ack_i
);

    localparam int              CH_W     = (N_IO > 1) ? $clog2(N_IO) : 1;
    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [32:0]     IO_LO    = {1'b0, IO_BASE};
    localparam logic [32:0]     IO_HI    = IO_LO + (33'(N_IO) << IO_WIN_LOG2);
    localparam logic [31:0]     WIN_MASK = (32'h0000_0001 << IO_WIN_LOG2) - 32'h0000_0001;
    localparam logic [N_IO-1:0] CE_CH0   = N_IO'(1);
    // Last ACCESS cycle before a timeout: TIMEOUT ack-less cycles in total.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mioc_state_e       state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              we_r;
    logic [1:0]        size_r;
    logic              sgn_r;
    logic [1:0]        addr_lo_r;
    logic              is_io_r;
    logic [CH_W-1:0]   chan_r;

    logic              mem_ce_r, mem_we_r, io_we_r, done_r, err_r;
    logic [3:0]        mem_sel_r, io_sel_r;
    logic [31:0]       mem_addr_r, mem_wdata_r, io_addr_r, io_wdata_r, rdata_r;
    logic [N_IO-1:0]   io_ce_r;

    logic              io_hit_s;
    logic [31:0]       offset_s;
    logic [CH_W-1:0]   chan_s;
    logic [1:0]        lane_size_s;
    logic [1:0]        lane_addr_s;
    logic              lane_sgn_s;
    logic [3:0]        sel_s;
    logic [31:0]       wdata_rep_s;
    logic [31:0]       rdata_ext_s;
    logic              misalign_s;
    logic              io_ack_sel_s;
    logic [31:0]       io_rd_sel_s;
    logic              tgt_ack_s;
    logic [31:0]       tgt_rd_s;

    // Address decode of the incoming request into memory or an IO window.
    always_comb begin
        io_hit_s = ({1'b0, req_addr_i} >= IO_LO) && ({1'b0, req_addr_i} < IO_HI);
        offset_s = req_addr_i - IO_BASE;
        chan_s   = CH_W'(offset_s >> IO_WIN_LOG2);
    end

    // Lane logic sees the live request in IDLE and the latched one afterwards.
    always_comb begin
        if (state_r == MiocIdle) begin
            lane_size_s = req_size_i;
            lane_addr_s = req_addr_i[1:0];
            lane_sgn_s  = req_signed_i;
        end else begin
            lane_size_s = size_r;
            lane_addr_s = addr_lo_r;
            lane_sgn_s  = sgn_r;
        end
    end

    mio_lane u_lane (
        .size      (lane_size_s),
        .addr_lo   (lane_addr_s),
        .sgn       (lane_sgn_s),
        .wdata     (req_wdata_i),
        .rdata     (tgt_rd_s),
        .sel       (sel_s),
        .wdata_rep (wdata_rep_s),
        .rdata_ext (rdata_ext_s),
        .misalign  (misalign_s)
    );

    // Only the selected target's ack and read data are observed.
    always_comb begin
        io_ack_sel_s = 1'b0;
        io_rd_sel_s  = ZeroWord;
        for (int k = 0; k < N_IO; k++) begin
            io_ack_sel_s = (chan_r == CH_W'(k)) ? io_ack_i[k] : io_ack_sel_s;
            io_rd_sel_s  = (chan_r == CH_W'(k)) ? io_rdata_i[32*k +: 32] : io_rd_sel_s;
        end
        tgt_ack_s = is_io_r ? io_ack_sel_s : mem_ack_i;
        tgt_rd_s  = is_io_r ? io_rd_sel_s  : mem_rdata_i;
    end

    // Controller FSM with registered bus and response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= MiocIdle;
            cnt_r       <= '0;
            we_r        <= 1'b0;
            size_r      <= 2'b00;
            sgn_r       <= 1'b0;
            addr_lo_r   <= 2'b00;
            is_io_r     <= 1'b0;
            chan_r      <= '0;
            mem_ce_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_sel_r   <= 4'b0000;
            mem_addr_r  <= ZeroWord;
            mem_wdata_r <= ZeroWord;
            io_ce_r     <= '0;
            io_we_r     <= 1'b0;
            io_sel_r    <= 4'b0000;
            io_addr_r   <= ZeroWord;
            io_wdata_r  <= ZeroWord;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            rdata_r     <= ZeroWord;
        end else begin
            case (state_r)
                MiocIdle: begin
                    done_r <= 1'b0;
                    err_r  <= 1'b0;
                    if (req_valid_i) begin
                        we_r      <= req_we_i;
                        size_r    <= req_size_i;
                        sgn_r     <= req_signed_i;
                        addr_lo_r <= req_addr_i[1:0];
                        is_io_r   <= io_hit_s;
                        chan_r    <= chan_s;
                        cnt_r     <= '0;
                        if (misalign_s) begin
                            // Faulting request: no bus cycle, straight to response.
                            state_r <= MiocResp;
                            done_r  <= 1'b1;
                            err_r   <= 1'b1;
                            rdata_r <= ZeroWord;
                        end else begin
                            state_r <= MiocAccess;
                            if (io_hit_s) begin
                                io_ce_r    <= CE_CH0 << chan_s;
                                io_we_r    <= req_we_i;
                                io_sel_r   <= sel_s;
                                io_addr_r  <= offset_s & WIN_MASK;
                                io_wdata_r <= wdata_rep_s;
                            end else begin
                                mem_ce_r    <= ChipEnable;
                                mem_we_r    <= req_we_i;
                                mem_sel_r   <= sel_s;
                                mem_addr_r  <= req_addr_i;
                                mem_wdata_r <= wdata_rep_s;
                            end
                        end
                    end else begin
                        state_r <= MiocIdle;
                    end
                end
                MiocAccess: begin
                    if (tgt_ack_s || (cnt_r == CNT_LAST)) begin
                        state_r     <= MiocResp;
                        done_r      <= 1'b1;
                        err_r       <= ~tgt_ack_s;
                        rdata_r     <= (tgt_ack_s && !we_r) ? rdata_ext_s : ZeroWord;
                        mem_ce_r    <= 1'b0;
                        mem_we_r    <= 1'b0;
                        mem_sel_r   <= 4'b0000;
                        mem_addr_r  <= ZeroWord;
                        mem_wdata_r <= ZeroWord;
                        io_ce_r     <= '0;
                        io_we_r     <= 1'b0;
                        io_sel_r    <= 4'b0000;
                        io_addr_r   <= ZeroWord;
                        io_wdata_r  <= ZeroWord;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                MiocResp: begin
                    state_r <= MiocIdle;
                    done_r  <= 1'b0;
                    err_r   <= 1'b0;
                end
                default: begin
                    state_r <= MiocIdle;
                    done_r  <= 1'b0;
                    err_r   <= 1'b0;
                end
            endcase
        end
    end

    // Stall is combinational in IDLE so the request is held from its first cycle.
    assign stallreq_o  = rst & (((state_r == MiocIdle) & req_valid_i) | (state_r == MiocAccess));
    assign done_o      = done_r;
    assign err_o       = err_r;
    assign rdata_o     = rdata_r;
    assign mem_ce_o    = mem_ce_r;
    assign mem_we_o    = mem_we_r;
    assign mem_sel_o   = mem_sel_r;
    assign mem_addr_o  = mem_addr_r;
    assign mem_wdata_o = mem_wdata_r;
    assign io_ce_o     = io_ce_r;
    assign io_we_o     = io_we_r;
    assign io_sel_o    = io_sel_r;
    assign io_addr_o   = io_addr_r;
    assign io_wdata_o  = io_wdata_r;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Self-checking bench for mio_bus_ctrl (default parameters: 4 windows of
// 256 bytes at 0x1000_0000, TIMEOUT = 15).
module tb_mio_bus_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req_valid_i = 1'b0;
    logic         req_we_i = 1'b0;
    logic [1:0]   req_size_i = 2'b00;
    logic         req_signed_i = 1'b0;
    logic [31:0]  req_addr_i = 32'h0;
    logic [31:0]  req_wdata_i = 32'h0;
    logic         stallreq_o, done_o, err_o;
    logic [31:0]  rdata_o;
    logic         mem_ce_o, mem_we_o;
    logic [3:0]   mem_sel_o;
    logic [31:0]  mem_addr_o, mem_wdata_o;
    logic [31:0]  mem_rdata_i = 32'h0;
    logic         mem_ack_i = 1'b0;
    logic [3:0]   io_ce_o;
    logic         io_we_o;
    logic [3:0]   io_sel_o;
    logic [31:0]  io_addr_o, io_wdata_o;
    logic [127:0] io_rdata_i = 128'h0;
    logic [3:0]   io_ack_i = 4'b0000;

    int n_cmp = 0;
    int n_bad = 0;

    mio_bus_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_size_i(req_size_i),
        .req_signed_i(req_signed_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .stallreq_o(stallreq_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
        .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .io_ce_o(io_ce_o), .io_we_o(io_we_o), .io_sel_o(io_sel_o),
        .io_addr_o(io_addr_o), .io_wdata_o(io_wdata_o),
        .io_rdata_i(io_rdata_i), .io_ack_i(io_ack_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;        // data the target returns
        logic        exp_err;
        logic        exp_io;
        logic [3:0]  exp_ce;    // io one-hot; 0 for memory
        logic [3:0]  exp_sel;
        logic [31:0] exp_baddr; // mem byte address or io window offset
        logic [31:0] exp_wdata; // checked on stores only
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic any_out();
        return stallreq_o | done_o | err_o | (|rdata_o) | mem_ce_o | mem_we_o |
               (|mem_sel_o) | (|mem_addr_o) | (|mem_wdata_o) | (|io_ce_o) | io_we_o |
               (|io_sel_o) | (|io_addr_o) | (|io_wdata_o);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Apply one vector with a zero-wait ack; entered and left in IDLE, #1 after an edge.
    task automatic run_vec(input int i, input vec_t v);
        int ch = 0;
        for (int k = 0; k < 4; k++) if (v.exp_ce[k]) ch = k;
        req_valid_i  = 1'b1;
        req_we_i     = v.we;
        req_size_i   = v.size;
        req_signed_i = v.sgn;
        req_addr_i   = v.addr;
        req_wdata_i  = v.wdata;
        io_rdata_i   = {4{32'hBAD0_BAD0}};
        if (v.exp_io) begin
            io_rdata_i[32*ch +: 32] = v.rd;
            mem_rdata_i = 32'h0BAD_0BAD;
        end else begin
            mem_rdata_i = v.rd;
        end
        #1;
        chk($sformatf("v%0d_stall_c0", i), {31'b0, stallreq_o}, 32'd1);
        next_cycle();
        if (v.exp_err) begin
            req_valid_i = 1'b0;
            chk($sformatf("v%0d_fault_done", i), {30'b0, done_o, err_o}, 32'd3);
            chk($sformatf("v%0d_fault_ce", i), {27'b0, io_ce_o, mem_ce_o}, 32'd0);
            chk($sformatf("v%0d_fault_stall", i), {31'b0, stallreq_o}, 32'd0);
        end else begin
            chk($sformatf("v%0d_ce", i), {27'b0, io_ce_o, mem_ce_o}, {27'b0, v.exp_ce, ~v.exp_io});
            chk($sformatf("v%0d_sel", i), {28'b0, v.exp_io ? io_sel_o : mem_sel_o}, {28'b0, v.exp_sel});
            chk($sformatf("v%0d_addr", i), v.exp_io ? io_addr_o : mem_addr_o, v.exp_baddr);
            chk($sformatf("v%0d_we", i), {31'b0, v.exp_io ? io_we_o : mem_we_o}, {31'b0, v.we});
            if (v.we) chk($sformatf("v%0d_wdata", i), v.exp_io ? io_wdata_o : mem_wdata_o, v.exp_wdata);
            chk($sformatf("v%0d_busy", i), {30'b0, stallreq_o, done_o}, 32'd2);
            if (v.exp_io) io_ack_i[ch] = 1'b1;
            else mem_ack_i = 1'b1;
            next_cycle();
            io_ack_i    = 4'b0000;
            mem_ack_i   = 1'b0;
            req_valid_i = 1'b0;
            chk($sformatf("v%0d_done", i), {29'b0, stallreq_o, done_o, err_o}, 32'd2);
            chk($sformatf("v%0d_rdata", i), rdata_o, v.exp_rdata);
            chk($sformatf("v%0d_ce_drop", i), {27'b0, io_ce_o, mem_ce_o}, 32'd0);
        end
        next_cycle();
        chk($sformatf("v%0d_idle", i), {31'b0, done_o}, 32'd0);
    endtask

    initial begin
        int cyc;
        int stalls;

        //          we    size   sgn   addr           wdata          rd             err   io    ce       sel      baddr          exp_wdata      exp_rdata
        vt[0]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b0, 4'b0000, 4'b1111, 32'h0000_0040, 32'h0000_0000, 32'hDEAD_BEEF};
        vt[1]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0043, 32'h0000_0000, 32'h1122_3380, 1'b0, 1'b0, 4'b0000, 4'b0001, 32'h0000_0043, 32'h0000_0000, 32'hFFFF_FF80};
        vt[2]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0043, 32'h0000_0000, 32'h1122_3380, 1'b0, 1'b0, 4'b0000, 4'b0001, 32'h0000_0043, 32'h0000_0000, 32'h0000_0080};
        vt[3]  = '{1'b1, 2'b01, 1'b0, 32'h1000_0204, 32'h0000_ABCD, 32'h0000_0000, 1'b0, 1'b1, 4'b0100, 4'b1100, 32'h0000_0004, 32'hABCD_ABCD, 32'h0000_0000};
        vt[4]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vt[5]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0000_0000, 32'h1234_8765, 1'b0, 1'b0, 4'b0000, 4'b0011, 32'h0000_0102, 32'h0000_0000, 32'hFFFF_8765};
        vt[6]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0100, 32'h0000_0000, 32'hF00D_1234, 1'b0, 1'b0, 4'b0000, 4'b1100, 32'h0000_0100, 32'h0000_0000, 32'h0000_F00D};
        vt[7]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h0000_005A, 32'h0000_0000, 1'b0, 1'b0, 4'b0000, 4'b0100, 32'h0000_0011, 32'h5A5A_5A5A, 32'h0000_0000};
        vt[8]  = '{1'b0, 2'b10, 1'b0, 32'h1000_03FC, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 1'b1, 4'b1000, 4'b1111, 32'h0000_00FC, 32'h0000_0000, 32'hCAFE_F00D};
        vt[9]  = '{1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vt[10] = '{1'b0, 2'b01, 1'b0, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vt[11] = '{1'b0, 2'b10, 1'b0, 32'h1000_0400, 32'h0000_0000, 32'h0102_0304, 1'b0, 1'b0, 4'b0000, 4'b1111, 32'h1000_0400, 32'h0000_0000, 32'h0102_0304};
        vt[12] = '{1'b0, 2'b10, 1'b0, 32'h0FFF_FFFC, 32'h0000_0000, 32'h5566_7788, 1'b0, 1'b0, 4'b0000, 4'b1111, 32'h0FFF_FFFC, 32'h0000_0000, 32'h5566_7788};
        vt[13] = '{1'b0, 2'b00, 1'b1, 32'h1000_0000, 32'h0000_0000, 32'h9A00_0000, 1'b0, 1'b1, 4'b0001, 4'b1000, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FF9A};
        vt[14] = '{1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h1357_9BDF, 32'h0000_0000, 1'b0, 1'b0, 4'b0000, 4'b1111, 32'h0000_0020, 32'h1357_9BDF, 32'h0000_0000};

        // Reset state: everything low, stall forced low even with a request pending.
        req_valid_i = 1'b1;
        req_size_i  = 2'b10;
        #12;
        chk("reset_outputs", {31'b0, any_out()}, 32'd0);
        @(posedge clk);
        #1;
        chk("reset_hold_outputs", {31'b0, any_out()}, 32'd0);
        req_valid_i = 1'b0;
        rst = 1'b1;
        next_cycle();
        chk("post_reset_idle", {31'b0, any_out()}, 32'd0);

        for (int i = 0; i < 15; i++) run_vec(i, vt[i]);

        // Ack while idle is ignored; then a load with two wait cycles.
        mem_ack_i = 1'b1;
        io_ack_i  = 4'b1111;
        next_cycle();
        next_cycle();
        chk("idle_ack_ignored", {30'b0, done_o, mem_ce_o}, 32'd0);
        mem_ack_i    = 1'b0;
        io_ack_i     = 4'b0000;
        req_valid_i  = 1'b1;
        req_we_i     = 1'b0;
        req_size_i   = 2'b10;
        req_signed_i = 1'b0;
        req_addr_i   = 32'h0000_0080;
        mem_rdata_i  = 32'h0F0E_0D0C;
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            chk($sformatf("wait_c%0d", c), {29'b0, stallreq_o, done_o, mem_ce_o}, 32'd5);
            if (c == 3) mem_ack_i = 1'b1;
        end
        next_cycle();
        mem_ack_i   = 1'b0;
        req_valid_i = 1'b0;
        chk("wait_done_c4", {29'b0, stallreq_o, done_o, err_o}, 32'd2);
        chk("wait_rdata", rdata_o, 32'h0F0E_0D0C);
        next_cycle();

        // Timeout on IO channel 1 while channel 2 and memory ack (ignored).
        req_valid_i = 1'b1;
        req_addr_i  = 32'h1000_0100;
        io_ack_i    = 4'b0100;
        mem_ack_i   = 1'b1;
        #1;
        stalls = stallreq_o ? 1 : 0;
        cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            next_cycle();
            cyc = c;
            if (done_o) break;
            if (c == 1) chk("to_ce", {28'b0, io_ce_o}, 32'h2);
            if (stallreq_o) stalls++;
        end
        io_ack_i    = 4'b0000;
        mem_ack_i   = 1'b0;
        req_valid_i = 1'b0;
        chk("to_done_cycle", cyc, 32'd16);
        chk("to_stall_cycles", stalls, 32'd16);
        chk("to_err", {30'b0, done_o, err_o}, 32'd3);
        chk("to_rdata", rdata_o, 32'h0000_0000);
        next_cycle();

        // Reset in the third ACCESS cycle aborts with no done.
        req_valid_i = 1'b1;
        req_addr_i  = 32'h0000_0044;
        next_cycle();
        next_cycle();
        next_cycle();
        chk("rst_pre_ce", {31'b0, mem_ce_o}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_async_clear", {31'b0, any_out()}, 32'd0);
        next_cycle();
        chk("rst_held_clear", {31'b0, any_out()}, 32'd0);
        req_valid_i = 1'b0;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            chk($sformatf("rst_after_c%0d", c), {30'b0, done_o, stallreq_o}, 32'd0);
        end
        run_vec(100, vt[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
